// File: rtl/regfile_sb.sv
// regfile_sb: parametrised architectural register file with a per-register
// busy scoreboard. Reads are combinational and see same-cycle writebacks
// (data and busy) so consumers never observe a one-cycle hole. Issue marks a
// destination busy from the next cycle; writeback clears it; flush clears all.
// Register 0 is hardwired to zero and is never busy.
module regfile_sb #(
    parameter int NREGS       = 32,
    parameter int XLEN        = 64,
    parameter int READ_PORTS  = 1,
    parameter int WRITE_PORTS = 1,
    parameter int ISSUE_PORTS = 1,
    localparam int AW         = $clog2(NREGS)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [READ_PORTS-1:0][AW-1:0]        ra1,
    input  logic [READ_PORTS-1:0][AW-1:0]        ra2,
    output logic [READ_PORTS-1:0][XLEN-1:0]      rd1,
    output logic [READ_PORTS-1:0][XLEN-1:0]      rd2,
    output logic [READ_PORTS-1:0]                rbusy1,
    output logic [READ_PORTS-1:0]                rbusy2,
    input  logic [WRITE_PORTS-1:0][AW-1:0]       wa,
    input  logic [WRITE_PORTS-1:0]               wvalid,
    input  logic [WRITE_PORTS-1:0][XLEN-1:0]     wd,
    input  logic [ISSUE_PORTS-1:0]               iss_valid,
    input  logic [ISSUE_PORTS-1:0][AW-1:0]       iss_addr,
    input  logic                                 flush
);

    logic [XLEN-1:0]  regs_r [NREGS];
    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_nxt_s;

    // Register storage: later write ports overwrite earlier ones, giving the
    // highest-index port priority; writes to x0 are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            for (int j = 0; j < WRITE_PORTS; j++) begin
                if (wvalid[j] && (wa[j] != '0)) begin
                    regs_r[wa[j]] <= wd[j];
                end
            end
        end
    end

    // Next busy vector: writeback clears first, then issue sets, so a
    // same-cycle issue and writeback to one register leaves it busy.
    always_comb begin
        busy_nxt_s = busy_r;
        if (flush) begin
            busy_nxt_s = '0;
        end else begin
            for (int j = 0; j < WRITE_PORTS; j++) begin
                if (wvalid[j]) begin
                    busy_nxt_s[wa[j]] = 1'b0;
                end else begin
                    busy_nxt_s[wa[j]] = busy_nxt_s[wa[j]];
                end
            end
            for (int k = 0; k < ISSUE_PORTS; k++) begin
                if (iss_valid[k]) begin
                    busy_nxt_s[iss_addr[k]] = 1'b1;
                end else begin
                    busy_nxt_s[iss_addr[k]] = busy_nxt_s[iss_addr[k]];
                end
            end
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // One bypassed read lane per rs1/rs2 of every read pair: even lanes are
    // rs1, odd lanes are rs2.
    for (genvar q = 0; q < 2 * READ_PORTS; q++) begin : g_rd
        logic [AW-1:0]   addr_s;
        logic [XLEN-1:0] data_s;
        logic            busy_s;

        if ((q % 2) == 0) begin : g_rs1
            assign addr_s       = ra1[q/2];
            assign rd1[q/2]     = data_s;
            assign rbusy1[q/2]  = busy_s;
        end else begin : g_rs2
            assign addr_s       = ra2[q/2];
            assign rd2[q/2]     = data_s;
            assign rbusy2[q/2]  = busy_s;
        end

        // Read mux with writeback bypass; the highest matching write port wins
        // and a bypassed source is by definition no longer busy.
        always_comb begin
            data_s = regs_r[addr_s];
            busy_s = busy_r[addr_s];
            for (int j = 0; j < WRITE_PORTS; j++) begin
                if (wvalid[j] && (wa[j] == addr_s)) begin
                    data_s = wd[j];
                    busy_s = 1'b0;
                end else begin
                    data_s = data_s;
                    busy_s = busy_s;
                end
            end
            if (addr_s == '0) begin
                data_s = '0;
                busy_s = 1'b0;
            end else begin
                data_s = data_s;
                busy_s = busy_s;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table for the called-out
// corner cases, randomized traffic against a behavioural model, and a reset
// sweep after random activity.
module tb_regfile_sb;

    localparam int NREGS = 16;
    localparam int XLEN  = 32;
    localparam int RP    = 2;
    localparam int WP    = 2;
    localparam int IP    = 2;
    localparam int AW    = 4;

    logic                       clk;
    logic                       reset;
    logic [RP-1:0][AW-1:0]      ra1, ra2;
    logic [RP-1:0][XLEN-1:0]    rd1, rd2;
    logic [RP-1:0]              rbusy1, rbusy2;
    logic [WP-1:0][AW-1:0]      wa;
    logic [WP-1:0]              wvalid;
    logic [WP-1:0][XLEN-1:0]    wd;
    logic [IP-1:0]              iss_valid;
    logic [IP-1:0][AW-1:0]      iss_addr;
    logic                       flush;

    int checks   = 0;
    int failures = 0;

    // behavioural reference state
    logic [XLEN-1:0] m_regs [NREGS];
    logic            m_busy [NREGS];

    regfile_sb #(
        .NREGS(NREGS), .XLEN(XLEN), .READ_PORTS(RP),
        .WRITE_PORTS(WP), .ISSUE_PORTS(IP)
    ) dut (
        .clk(clk), .reset(reset),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .rbusy1(rbusy1), .rbusy2(rbusy2),
        .wa(wa), .wvalid(wvalid), .wd(wd),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]      wv;
        logic [AW-1:0]   wa0;
        logic [XLEN-1:0] wd0;
        logic [AW-1:0]   wa1;
        logic [XLEN-1:0] wd1;
        logic [1:0]      iv;
        logic [AW-1:0]   ia0;
        logic            fl;
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] exp_rd;
        logic            exp_busy;
    } vec_t;

    vec_t tv [19];

    function automatic vec_t mk(logic [1:0] wv, logic [AW-1:0] wa0, logic [XLEN-1:0] wd0,
                                logic [AW-1:0] wa1, logic [XLEN-1:0] wd1,
                                logic [1:0] iv, logic [AW-1:0] ia0, logic fl,
                                logic [AW-1:0] ra, logic [XLEN-1:0] er, logic eb);
        vec_t v;
        v.wv = wv; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.iv = iv; v.ia0 = ia0; v.fl = fl; v.ra = ra;
        v.exp_rd = er; v.exp_busy = eb;
        return v;
    endfunction

    task automatic chk(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // expected read data: x0 is zero, otherwise the last matching write port wins
    function automatic logic [XLEN-1:0] exp_rd(logic [AW-1:0] a);
        logic [XLEN-1:0] r;
        if (a == 4'd0) return 32'd0;
        r = m_regs[a];
        for (int j = 0; j < WP; j++)
            if (wvalid[j] && wa[j] == a) r = wd[j];
        return r;
    endfunction

    function automatic logic exp_busy(logic [AW-1:0] a);
        if (a == 4'd0) return 1'b0;
        for (int j = 0; j < WP; j++)
            if (wvalid[j] && wa[j] == a) return 1'b0;
        return m_busy[a];
    endfunction

    // reference state update for the edge just taken
    task automatic model_update();
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                m_regs[i] = 32'd0;
                m_busy[i] = 1'b0;
            end
        end else begin
            for (int j = 0; j < WP; j++)
                if (wvalid[j] && wa[j] != 4'd0) m_regs[wa[j]] = wd[j];
            if (flush) begin
                for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
            end else begin
                for (int j = 0; j < WP; j++)
                    if (wvalid[j]) m_busy[wa[j]] = 1'b0;
                for (int k = 0; k < IP; k++)
                    if (iss_valid[k] && iss_addr[k] != 4'd0) m_busy[iss_addr[k]] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_in();
        reset = 1'b0; flush = 1'b0;
        wvalid = '0; wa = '0; wd = '0;
        iss_valid = '0; iss_addr = '0;
        ra1 = '0; ra2 = '0;
    endtask

    task automatic check_model(string tag);
        for (int p = 0; p < RP; p++) begin
            chk($sformatf("%s_rd1[%0d]", tag, p), rd1[p], exp_rd(ra1[p]));
            chk($sformatf("%s_rd2[%0d]", tag, p), rd2[p], exp_rd(ra2[p]));
            chk($sformatf("%s_rbusy1[%0d]", tag, p), {31'd0, rbusy1[p]}, {31'd0, exp_busy(ra1[p])});
            chk($sformatf("%s_rbusy2[%0d]", tag, p), {31'd0, rbusy2[p]}, {31'd0, exp_busy(ra2[p])});
        end
    endtask

    initial begin
        clear_in();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        //           wv     wa0   wd0           wa1   wd1       iv     ia0   fl    ra    exp_rd        busy
        tv[0]  = mk(2'b01, 4'd5, 32'hDEAD,     4'd0, 32'd0,    2'b00, 4'd0, 1'b0, 4'd5, 32'hDEAD,     1'b0);
        tv[1]  = mk(2'b00, 4'd0, 32'd0,        4'd0, 32'd0,    2'b00, 4'd0, 1'b0, 4'd5, 32'hDEAD,     1'b0);
        tv[2]  = mk(2'b01, 4'd0, 32'h1234,     4'd0, 32'd0,    2'b01, 4'd0, 1'b0, 4'd0, 32'd0,        1'b0);
        tv[3]  = mk(2'b00, 4'd0, 32'd0,        4'd0, 32'd0,    2'b00, 4'd0, 1'b0, 4'd0, 32'd0,        1'b0);
        tv[4]  = mk(2'b11, 4'd7, 32'd1,        4'd7, 32'd2,    2'b00, 4'd0, 1'b0, 4'd7, 32'd2,        1'b0);
        tv[5]  = mk(2'b00, 4'd0, 32'd0,        4'd0, 32'd0,    2'b00, 4'd0, 1'b0, 4'd7, 32'd2,        1'b0);
        tv[6]  = mk(2'b00, 4'd0, 32'd0,        4'd0, 32'd0,    2'b01, 4'd3, 1'b0, 4'd3, 32'd0,        1'b0);
        tv[7]  = mk(2'b00, 4'd0, 32'd0,        4'd0, 32'd0,    2'b00, 4'd0, 1'b0, 4'd3, 32'd0,        1'b1);
        tv[8]  = mk(2'b01, 4'd3, 32'h33,       4'd0, 32'd0,    2'b00, 4'd0, 1'b0, 4'd3, 32'h33,       1'b0);
        tv[9]  = mk(2'b00, 4'd0, 32'd0,        4'd0, 32'd0,    2'b00, 4'd0, 1'b0, 4'd3, 32'h33,       1'b0);
        tv[10] = mk(2'b01, 4'd3, 32'h44,       4'd0, 32'd0,    2'b01, 4'd3, 1'b0, 4'd3, 32'h44,       1'b0);
        tv[11] = mk(2'b00, 4'd0, 32'd0,        4'd0, 32'd0,    2'b00, 4'd0, 1'b0, 4'd3, 32'h44,       1'b1);
        tv[12] = mk(2'b00, 4'd0, 32'd0,        4'd0, 32'd0,    2'b01, 4'd4, 1'b0, 4'd4, 32'd0,        1'b0);
        tv[13] = mk(2'b00, 4'd0, 32'd0,        4'd0, 32'd0,    2'b01, 4'd5, 1'b1, 4'd3, 32'h44,       1'b1);
        tv[14] = mk(2'b00, 4'd0, 32'd0,        4'd0, 32'd0,    2'b00, 4'd0, 1'b0, 4'd3, 32'h44,       1'b0);
        tv[15] = mk(2'b00, 4'd0, 32'd0,        4'd0, 32'd0,    2'b00, 4'd0, 1'b0, 4'd4, 32'd0,        1'b0);
        tv[16] = mk(2'b00, 4'd0, 32'd0,        4'd0, 32'd0,    2'b00, 4'd0, 1'b0, 4'd5, 32'hDEAD,     1'b0);
        tv[17] = mk(2'b01, 4'd6, 32'h66,       4'd0, 32'd0,    2'b01, 4'd6, 1'b1, 4'd6, 32'h66,       1'b0);
        tv[18] = mk(2'b00, 4'd0, 32'd0,        4'd0, 32'd0,    2'b00, 4'd0, 1'b0, 4'd6, 32'h66,       1'b0);

        // directed vectors, checked before the edge on which they act
        for (int k = 0; k < 19; k++) begin
            clear_in();
            wvalid = tv[k].wv;
            wa[0] = tv[k].wa0; wd[0] = tv[k].wd0;
            wa[1] = tv[k].wa1; wd[1] = tv[k].wd1;
            iss_valid = tv[k].iv;
            iss_addr[0] = tv[k].ia0;
            flush = tv[k].fl;
            ra1[0] = tv[k].ra;
            #4;
            chk($sformatf("vec%0d_rd", k), rd1[0], tv[k].exp_rd);
            chk($sformatf("vec%0d_rbusy", k), {31'd0, rbusy1[0]}, {31'd0, tv[k].exp_busy});
            tick();
        end

        // randomized traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 59) == 0);
            flush = ($urandom_range(0, 15) == 0);
            for (int j = 0; j < WP; j++) begin
                wvalid[j] = ($urandom_range(0, 2) != 0);
                wa[j]     = AW'($urandom_range(0, NREGS - 1));
                wd[j]     = $urandom;
            end
            for (int k = 0; k < IP; k++) begin
                iss_valid[k] = ($urandom_range(0, 1) != 0);
                iss_addr[k]  = AW'($urandom_range(0, NREGS - 1));
            end
            for (int p = 0; p < RP; p++) begin
                ra1[p] = ($urandom_range(0, 3) == 0) ? wa[0] : AW'($urandom_range(0, NREGS - 1));
                ra2[p] = ($urandom_range(0, 3) == 0) ? wa[1] : AW'($urandom_range(0, NREGS - 1));
            end
            #4;
            check_model($sformatf("rnd%0d", c));
            tick();
        end

        // reset sweep: random writes/issues, then reset with writes still active
        for (int c = 0; c < 20; c++) begin
            clear_in();
            wvalid = 2'b11;
            wa[0] = AW'($urandom_range(1, NREGS - 1)); wd[0] = $urandom;
            wa[1] = AW'($urandom_range(1, NREGS - 1)); wd[1] = $urandom;
            iss_valid = 2'b11;
            iss_addr[0] = AW'($urandom_range(1, NREGS - 1));
            iss_addr[1] = AW'($urandom_range(1, NREGS - 1));
            tick();
        end
        reset = 1'b1;
        tick();
        clear_in();
        for (int a = 0; a < NREGS; a += 2) begin
            for (int p = 0; p < RP; p++) begin
                ra1[p] = AW'(a);
                ra2[p] = AW'(a + 1);
            end
            #4;
            for (int p = 0; p < RP; p++) begin
                chk($sformatf("rst_rd1_x%0d", a), rd1[p], 32'd0);
                chk($sformatf("rst_rd2_x%0d", a + 1), rd2[p], 32'd0);
                chk($sformatf("rst_rbusy1_x%0d", a), {31'd0, rbusy1[p]}, 32'd0);
                chk($sformatf("rst_rbusy2_x%0d", a + 1), {31'd0, rbusy2[p]}, 32'd0);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
